// File: rtl/serial_add_if.sv
// Handshake bundle for serial_add_stage: operand input channel and result output channel.
// Carries the ovf signal only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
`endif
endinterface

// File: rtl/serial_add_stage.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_stage #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_add_if.slave   bus
);

   localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q,     state_d;
   logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
   logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
   logic [WIDTH-1:0]   sum_sh_q,    sum_sh_d;
   logic               carry_q,     carry_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [WIDTH-1:0]   sum_q,       sum_d;
   logic               cout_q,      cout_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q,      busy_d;
`ifdef SERIAL_ADD_OVF_EN
   logic               ovf_q,       ovf_d;
`endif

   logic               fa_s;
   logic               fa_c;
   logic [WIDTH-1:0]   sum_sh_next;

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      sum_sh_d    = sum_sh_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d       = ovf_q;
`endif

      fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

      // Sum bits enter at the MSB and walk down, so after WIDTH steps bit 0 is the first sum bit.
      sum_sh_next = sum_sh_q;
      for (int i = 0; i < WIDTH - 1; i++) begin
         sum_sh_next[i] = sum_sh_q[i+1];
      end
      sum_sh_next[WIDTH-1] = fa_s;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               carry_d  = bus.cin;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = sum_sh_next;
            carry_d  = fa_c;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
               sum_d   = sum_sh_next;
               cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q is the carry into the MSB on the last step, fa_c the carry out of it.
               ovf_d   = carry_q ^ fa_c;
`endif
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
   // NOTE: datapath registers are reset too, so a reset result reads as zero rather than stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_sh_q    <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_sh_q    <= sum_sh_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.busy      = busy_q;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_stage.sv
// Self-checking bench for serial_add_stage: WIDTH=8 instance for directed/random/stall/reset
// scenarios and a WIDTH=4 instance for the exhaustive back-to-back sweep.
module tb_serial_add_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   fails     = 0;

   always #5 clk = ~clk;

   serial_add_if #(.WIDTH(8)) bus8 ();
   serial_add_if #(.WIDTH(4)) bus4 ();

   serial_add_stage #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_add_stage #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer addition; overflow when same-sign operands give a different-sign sum.
   function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int unsigned t;
      t = int'(a) + int'(b) + int'(c);
      return t[8:0];
   endfunction

   function automatic logic ref_ovf8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
      return (a[7] == b[7]) && (s[7] != a[7]);
   endfunction

   // One complete operation on the WIDTH=8 instance, holding the result for 'stall' extra cycles.
   task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int stall);
      logic [8:0] exp;
      int         lat;
      exp = ref_add8(a, b, c);
      bus8.a = a; bus8.b = b; bus8.cin = c;
      bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
      tests_run++;
      if (bus8.in_ready !== 1'b1) begin
         fails++; $display("FAIL %s in_ready before accept: got %b want 1", name, bus8.in_ready);
      end
      tick();
      bus8.in_valid = 1'b0;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      tests_run++;
      if (lat !== 8) begin
         fails++; $display("FAIL %s latency: got %0d want 8", name, lat);
      end
      tests_run++;
      if (bus8.sum !== exp[7:0] || bus8.cout !== exp[8]) begin
         fails++; $display("FAIL %s result: got sum=%h cout=%b want sum=%h cout=%b",
                           name, bus8.sum, bus8.cout, exp[7:0], exp[8]);
      end
`ifdef SERIAL_ADD_OVF_EN
      tests_run++;
      if (bus8.ovf !== ref_ovf8(a, b, exp[7:0])) begin
         fails++; $display("FAIL %s ovf: got %b want %b", name, bus8.ovf, ref_ovf8(a, b, exp[7:0]));
      end
`endif
      tests_run++;
      if (bus8.busy !== 1'b1 || bus8.in_ready !== 1'b0) begin
         fails++; $display("FAIL %s done flags: got busy=%b in_ready=%b want 1 0",
                           name, bus8.busy, bus8.in_ready);
      end
      repeat (stall) tick();
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      tests_run++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0) begin
         fails++; $display("FAIL %s return to idle: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                           name, bus8.out_valid, bus8.in_ready, bus8.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      tests_run++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 ||
          bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
         fails++; $display("FAIL reset8: got in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                           bus8.in_ready, bus8.out_valid, bus8.busy, bus8.sum, bus8.cout);
      end
`ifdef SERIAL_ADD_OVF_EN
      tests_run++;
      if (bus8.ovf !== 1'b0) begin
         fails++; $display("FAIL reset ovf: got %b want 0", bus8.ovf);
      end
`endif
      tests_run++;
      if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.sum !== 4'h0) begin
         fails++; $display("FAIL reset4: got in_ready=%b out_valid=%b sum=%h want 1 0 0",
                           bus4.in_ready, bus4.out_valid, bus4.sum);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      do_op("dir_0f_01",   8'h0F, 8'h01, 1'b0, 0);
      do_op("dir_ff_01",   8'hFF, 8'h01, 1'b0, 0);
      do_op("dir_7f_01",   8'h7F, 8'h01, 1'b0, 0);
      do_op("dir_00_00_c", 8'h00, 8'h00, 1'b1, 0);
      do_op("dir_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0);
      do_op("dir_80_80",   8'h80, 8'h80, 1'b0, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_op("random", 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_stall();
      logic [8:0] exp;
      int         lat;
      exp = ref_add8(8'h3C, 8'hC5, 1'b1);
      bus8.a = 8'h3C; bus8.b = 8'hC5; bus8.cin = 1'b1;
      bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
      tick();
      bus8.in_valid = 1'b0;
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      bus8.in_valid = 1'b1; bus8.a = 8'h55; bus8.b = 8'h66; bus8.cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests_run++;
         if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 ||
             bus8.sum !== exp[7:0] || bus8.cout !== exp[8]) begin
            fails++; $display("FAIL stall cycle %0d: got out_valid=%b in_ready=%b sum=%h cout=%b want 1 0 %h %b",
                              i, bus8.out_valid, bus8.in_ready, bus8.sum, bus8.cout, exp[7:0], exp[8]);
         end
      end
      bus8.in_valid = 1'b0;
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      tests_run++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.sum !== exp[7:0]) begin
         fails++; $display("FAIL stall release: got out_valid=%b in_ready=%b sum=%h want 0 1 %h",
                           bus8.out_valid, bus8.in_ready, bus8.sum, exp[7:0]);
      end
      tick();
      tests_run++;
      if (bus8.busy !== 1'b0) begin
         fails++; $display("FAIL stall no reload: got busy=%b want 0", bus8.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int seen;
      bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
      bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++;
      if (bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0 || bus8.out_valid !== 1'b0) begin
         fails++; $display("FAIL mid-run reset: got in_ready=%b busy=%b out_valid=%b want 1 0 0",
                           bus8.in_ready, bus8.busy, bus8.out_valid);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus8.out_valid === 1'b1) seen++;
      end
      bus8.out_ready = 1'b0;
      tests_run++;
      if (seen !== 0) begin
         fails++; $display("FAIL aborted op produced result: got %0d out_valid cycles want 0", seen);
      end
      do_op("after_reset_22_11", 8'h22, 8'h11, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_q[$];
      logic [4:0] exp;
      int         idx;
      int         cyc;
      int         last_cyc;
      int         results;
      idx = 0; cyc = 0; last_cyc = -1; results = 0;
      bus4.out_ready = 1'b1;
      while ((idx < 512 || exp_q.size() != 0) && cyc < 512 * 6 + 100) begin
         if (bus4.out_valid === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               fails++; $display("FAIL b2b unexpected result: sum=%h cout=%b", bus4.sum, bus4.cout);
            end else begin
               exp = exp_q.pop_front();
               if (bus4.sum !== exp[3:0] || bus4.cout !== exp[4]) begin
                  fails++; $display("FAIL b2b result %0d: got sum=%h cout=%b want sum=%h cout=%b",
                                    results, bus4.sum, bus4.cout, exp[3:0], exp[4]);
               end
            end
            if (last_cyc >= 0) begin
               tests_run++;
               if (cyc - last_cyc !== 6) begin
                  fails++; $display("FAIL b2b interval: got %0d want 6", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            results++;
         end
         if (bus4.in_ready === 1'b1 && idx < 512) begin
            bus4.a   = 4'(idx >> 5);
            bus4.b   = 4'(idx >> 1);
            bus4.cin = 1'(idx);
            bus4.in_valid = 1'b1;
            exp_q.push_back(5'((idx >> 5) % 16 + (idx >> 1) % 16 + idx % 2));
            idx++;
         end else if (idx >= 512) begin
            bus4.in_valid = 1'b0;
         end
         tick();
         cyc++;
      end
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b0;
      tests_run++;
      if (results !== 512) begin
         fails++; $display("FAIL b2b result count: got %0d want 512", results);
      end
   endtask

   initial begin
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
      bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
      bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
